// File: rtl/cpu_bus_mem.sv
`default_nettype none
// cpu_bus_mem: clk4 divider with qclk taps, phase-strobed mirrored RAM, 6502 vector registers, open-bus read-back.
// Optional write protection above WP_BASE (with sticky wp_hit) when CPU_BUS_MEM_WP_EN is defined.
module cpu_bus_mem #(
    parameter int                 ADDR_W   = 16,
    parameter int                 DEPTH    = 2048,
    parameter logic [ADDR_W-1:0]  MAP_TOP  = 16'h2000,
    parameter int                 DIV      = 4,
    parameter int                 PHASES   = 3,
    parameter int                 RD_PHASE = 0,
    parameter logic [15:0]        NMI_VEC  = 16'h0000,
    parameter logic [15:0]        RST_VEC  = 16'h0001,
    parameter logic [15:0]        IRQ_VEC  = 16'h0001,
    parameter logic [ADDR_W-1:0]  WP_BASE  = 16'h8000
) (
    input  logic              clk4,
    input  logic              n_reset,
    output logic              clk,
    output logic [PHASES-1:0] qclk,
    output logic              bus_stb,
    input  logic [ADDR_W-1:0] addr,
    input  logic              rw,
    input  logic [7:0]        din,
    output logic [7:0]        dout,
    output logic              doe,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data
`ifdef CPU_BUS_MEM_WP_EN
    ,
    output logic              wp_hit
`endif
);

    localparam int HALF  = DIV / 2;
    localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);
`ifdef CPU_BUS_MEM_WP_EN
    localparam bit WP_ON = 1'b1;
`else
    localparam bit WP_ON = 1'b0;
`endif

    logic [CNT_W-1:0] div_cnt;
    logic             tap_prev;
    logic [7:0]       mem [DEPTH];
    logic [7:0]       vec_reg [6];
    logic [7:0]       rd_data;
    logic             cpu_vec, cpu_ram, ld_vec, ld_ram;
    logic             wp_block, cpu_wr;

    // Vectors take priority so a MAP_TOP covering $FFFA-$FFFF cannot shadow them.
    function automatic logic is_vec(input logic [ADDR_W-1:0] a);
        return (&a[ADDR_W-1:3]) && (a[2:1] != 2'b00);
    endfunction

    function automatic logic is_ram(input logic [ADDR_W-1:0] a);
        return !is_vec(a) && (a < MAP_TOP);
    endfunction

    function automatic logic [2:0] vec_idx(input logic [ADDR_W-1:0] a);
        return a[2:0] - 3'd2;
    endfunction

    function automatic logic [IDX_W-1:0] ram_idx(input logic [ADDR_W-1:0] a);
        return a[IDX_W-1:0];
    endfunction

    always_ff @(posedge clk4 or negedge n_reset) begin
        if (!n_reset) begin
            div_cnt <= '0;
            clk     <= 1'b0;
        end else if (div_cnt == CNT_LAST) begin
            div_cnt <= '0;
            clk     <= ~clk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    generate
        if (PHASES == 1) begin : g_tap_one
            always_ff @(posedge clk4 or negedge n_reset) begin
                if (!n_reset) qclk <= '0;
                else          qclk <= clk;
            end
        end else begin : g_tap_many
            always_ff @(posedge clk4 or negedge n_reset) begin
                if (!n_reset) qclk <= '0;
                else          qclk <= {qclk[PHASES-2:0], clk};
            end
        end
    endgenerate

    always_ff @(posedge clk4 or negedge n_reset) begin
        if (!n_reset) begin
            tap_prev <= 1'b0;
            bus_stb  <= 1'b0;
        end else begin
            tap_prev <= qclk[RD_PHASE];
            bus_stb  <= qclk[RD_PHASE] & ~tap_prev;
        end
    end

    always_comb begin
        cpu_vec  = is_vec(addr);
        cpu_ram  = is_ram(addr);
        ld_vec   = is_vec(ld_addr);
        ld_ram   = is_ram(ld_addr);
        wp_block = WP_ON && (addr >= WP_BASE);
        cpu_wr   = bus_stb && !rw && !wp_block;
    end

    // Open bus falls through to the current dout so a read leaves it unchanged.
    always_comb begin
        rd_data = dout;
        if (cpu_vec)      rd_data = vec_reg[vec_idx(addr)];
        else if (cpu_ram) rd_data = mem[ram_idx(addr)];
    end

    // Host preload is written last so it wins a same-location collision.
    always_ff @(posedge clk4) begin
        if (cpu_wr && cpu_ram) mem[ram_idx(addr)] <= din;
        if (ld_en && ld_ram)   mem[ram_idx(ld_addr)] <= ld_data;
    end

    always_ff @(posedge clk4 or negedge n_reset) begin
        if (!n_reset) begin
            vec_reg[0] <= NMI_VEC[7:0];
            vec_reg[1] <= NMI_VEC[15:8];
            vec_reg[2] <= RST_VEC[7:0];
            vec_reg[3] <= RST_VEC[15:8];
            vec_reg[4] <= IRQ_VEC[7:0];
            vec_reg[5] <= IRQ_VEC[15:8];
        end else begin
            if (cpu_wr && cpu_vec) vec_reg[vec_idx(addr)] <= din;
            if (ld_en && ld_vec)   vec_reg[vec_idx(ld_addr)] <= ld_data;
        end
    end

    always_ff @(posedge clk4 or negedge n_reset) begin
        if (!n_reset) begin
            dout <= 8'h00;
            doe  <= 1'b0;
        end else begin
            doe <= rw;
            if (bus_stb && rw) dout <= rd_data;
        end
    end

`ifdef CPU_BUS_MEM_WP_EN
    always_ff @(posedge clk4 or negedge n_reset) begin
        if (!n_reset)                           wp_hit <= 1'b0;
        else if (bus_stb && !rw && wp_block)    wp_hit <= 1'b1;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_bus_mem.sv
`default_nettype none
// tb_cpu_bus_mem: directed checks of divider/tap timing, vectors, mirroring, collisions and async reset.
module tb_cpu_bus_mem;

    logic        clk4 = 1'b0;
    logic        n_reset;
    logic        clk;
    logic [2:0]  qclk;
    logic        bus_stb;
    logic [15:0] addr;
    logic        rw;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        doe;
    logic        ld_en;
    logic [15:0] ld_addr;
    logic [7:0]  ld_data;
`ifdef CPU_BUS_MEM_WP_EN
    logic        wp_hit;
    localparam bit WP = 1'b1;
`else
    localparam bit WP = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    cpu_bus_mem dut (
        .clk4    (clk4),
        .n_reset (n_reset),
        .clk     (clk),
        .qclk    (qclk),
        .bus_stb (bus_stb),
        .addr    (addr),
        .rw      (rw),
        .din     (din),
        .dout    (dout),
        .doe     (doe),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data)
`ifdef CPU_BUS_MEM_WP_EN
        ,
        .wp_hit  (wp_hit)
`endif
    );

    always #5 clk4 = ~clk4;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; waits for the strobe, optionally fires a host write on the same edge.
    task automatic cpu_cycle(input logic [15:0] a, input logic r, input logic [7:0] d,
                             input logic ld, input logic [7:0] ld_d);
        int n = 0;
        addr = a; rw = r; din = d;
        while (bus_stb !== 1'b1 && n < 16) begin
            @(negedge clk4);
            n++;
        end
        check("stb_wait", {15'd0, bus_stb}, 16'd1);
        if (ld) begin
            ld_en = 1'b1; ld_addr = a; ld_data = ld_d;
        end
        @(negedge clk4);
        ld_en = 1'b0;
        addr  = 16'h4000;
        rw    = 1'b1;
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk4);
        ld_en = 1'b0;
    endtask

    // {clk, qclk[2:0], bus_stb} after each of the first 8 clk4 edges following release
    logic [4:0] tap_exp [8];

    initial begin
        int n;
        tap_exp[0] = 5'b00000; tap_exp[1] = 5'b10000;
        tap_exp[2] = 5'b10010; tap_exp[3] = 5'b00111;
        tap_exp[4] = 5'b01100; tap_exp[5] = 5'b11000;
        tap_exp[6] = 5'b10010; tap_exp[7] = 5'b00111;

        n_reset = 1'b0; addr = 16'h4000; rw = 1'b1; din = 8'h00;
        ld_en = 1'b0; ld_addr = 16'h0000; ld_data = 8'h00;
        #1;
        check("rst_taps", {11'd0, clk, qclk, bus_stb}, 16'd0);
        check("rst_dout", {8'd0, dout}, 16'h0000);
        check("rst_doe", {15'd0, doe}, 16'd0);
        @(negedge clk4);
        @(negedge clk4);
        n_reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk4);
            check($sformatf("taps_%0d", i), {11'd0, clk, qclk, bus_stb}, {11'd0, tap_exp[i]});
        end

        cpu_cycle(16'hFFFC, 1'b1, 8'h00, 1'b0, 8'h00);
        check("vec_fffc", {8'd0, dout}, 16'h0001);
        check("doe_read", {15'd0, doe}, 16'd1);
        cpu_cycle(16'hFFFD, 1'b1, 8'h00, 1'b0, 8'h00);
        check("vec_fffd", {8'd0, dout}, 16'h0000);
        cpu_cycle(16'hFFFD, 1'b0, 8'h80, 1'b0, 8'h00);
        cpu_cycle(16'hFFFD, 1'b1, 8'h00, 1'b0, 8'h00);
        check("vec_fffd_wr", {8'd0, dout}, WP ? 16'h0000 : 16'h0080);
`ifdef CPU_BUS_MEM_WP_EN
        check("wp_hit_set", {15'd0, wp_hit}, 16'd1);
        cpu_cycle(16'hFFFE, 1'b0, 8'h55, 1'b0, 8'h00);
        cpu_cycle(16'hFFFE, 1'b1, 8'h00, 1'b0, 8'h00);
        check("wp_fffe", {8'd0, dout}, 16'h0001);
`endif

        preload(16'h0000, 8'hA2);
        preload(16'h0001, 8'h03);
        cpu_cycle(16'h0800, 1'b1, 8'h00, 1'b0, 8'h00);
        check("mirror_0800", {8'd0, dout}, 16'h00A2);
        cpu_cycle(16'h1801, 1'b1, 8'h00, 1'b0, 8'h00);
        check("mirror_1801", {8'd0, dout}, 16'h0003);

        cpu_cycle(16'h0001, 1'b0, 8'h34, 1'b0, 8'h00);
        check("doe_write", {15'd0, doe}, 16'd0);
        check("dout_hold_wr", {8'd0, dout}, 16'h0003);
        cpu_cycle(16'h0801, 1'b1, 8'h00, 1'b0, 8'h00);
        check("wr_0801", {8'd0, dout}, 16'h0034);
        cpu_cycle(16'h4000, 1'b1, 8'h00, 1'b0, 8'h00);
        check("open_bus", {8'd0, dout}, 16'h0034);
        check("open_doe", {15'd0, doe}, 16'd1);

        cpu_cycle(16'h0005, 1'b0, 8'h22, 1'b1, 8'h11);
        cpu_cycle(16'h0005, 1'b1, 8'h00, 1'b0, 8'h00);
        check("ld_wins", {8'd0, dout}, 16'h0011);

        preload(16'h0010, 8'hAA);
        cpu_cycle(16'h0010, 1'b1, 8'h00, 1'b1, 8'hBB);
        check("rd_old", {8'd0, dout}, 16'h00AA);
        cpu_cycle(16'h0010, 1'b1, 8'h00, 1'b0, 8'h00);
        check("rd_new", {8'd0, dout}, 16'h00BB);

        preload(16'h07FF, 8'h5A);
        cpu_cycle(16'h0800, 1'b0, 8'hC3, 1'b0, 8'h00);
        cpu_cycle(16'h0000, 1'b1, 8'h00, 1'b0, 8'h00);
        check("wrap_0800", {8'd0, dout}, 16'h00C3);
        cpu_cycle(16'h0FFF, 1'b1, 8'h00, 1'b0, 8'h00);
        check("wrap_0fff", {8'd0, dout}, 16'h005A);
        cpu_cycle(16'h1FFF, 1'b1, 8'h00, 1'b0, 8'h00);
        check("wrap_1fff", {8'd0, dout}, 16'h005A);
        cpu_cycle(16'h2000, 1'b1, 8'h00, 1'b0, 8'h00);
        check("map_top", {8'd0, dout}, 16'h005A);

        n = 0;
        while (clk !== 1'b1 && n < 16) begin
            @(negedge clk4);
            n++;
        end
        check("clk_high", {15'd0, clk}, 16'd1);
        #2 n_reset = 1'b0;
        #1;
        check("mid_rst_taps", {11'd0, clk, qclk, bus_stb}, 16'd0);
        check("mid_rst_dout", {8'd0, dout}, 16'h0000);
        check("mid_rst_doe", {15'd0, doe}, 16'd0);
`ifdef CPU_BUS_MEM_WP_EN
        check("mid_rst_wp", {15'd0, wp_hit}, 16'd0);
`endif
        @(negedge clk4);
        n_reset = 1'b1;
        @(negedge clk4);
        check("restart_1", {15'd0, clk}, 16'd0);
        @(negedge clk4);
        check("restart_2", {15'd0, clk}, 16'd1);

        cpu_cycle(16'hFFFD, 1'b1, 8'h00, 1'b0, 8'h00);
        check("vec_reset", {8'd0, dout}, 16'h0000);
        cpu_cycle(16'hFFFC, 1'b1, 8'h00, 1'b0, 8'h00);
        check("vec_rst_lo", {8'd0, dout}, 16'h0001);
        cpu_cycle(16'h0801, 1'b1, 8'h00, 1'b0, 8'h00);
        check("ram_kept", {8'd0, dout}, 16'h0034);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
